// File: rtl/banks_to_mem.sv
// Gathers one request per bank into a single wide memory request and
// scatters the wide read response back to every bank.
module banks_to_mem #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AtopWidth = 6,
    parameter int unsigned NumBanks  = 2,
    parameter int unsigned MaxTrans  = 4,
    parameter type         atop_t    = logic [AtopWidth-1:0]
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumBanks-1:0]              bank_req_i,
    output logic [NumBanks-1:0]              bank_gnt_o,
    input  logic [NumBanks*AddrWidth-1:0]    bank_addr_i,
    input  logic [DataWidth-1:0]             bank_wdata_i,
    input  logic [DataWidth/8-1:0]           bank_strb_i,
    input  logic [NumBanks*AtopWidth-1:0]    bank_atop_i,
    input  logic [NumBanks-1:0]              bank_we_i,
    output logic [NumBanks-1:0]              bank_rvalid_o,
    output logic [DataWidth-1:0]             bank_rdata_o,
    output logic                             req_o,
    input  logic                             gnt_i,
    output logic [AddrWidth-1:0]             addr_o,
    output logic [DataWidth-1:0]             wdata_o,
    output logic [DataWidth/8-1:0]           strb_o,
    output atop_t                            atop_o,
    output logic                             we_o,
    input  logic                             rvalid_i,
    input  logic [DataWidth-1:0]             rdata_i
);

    localparam int unsigned BankDW = DataWidth / NumBanks;
    localparam int unsigned BankSW = BankDW / 8;
    localparam int unsigned StrbW  = DataWidth / 8;
    localparam int unsigned CntW   = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(StrbW - 1);

    logic [NumBanks-1:0]             valid_q, valid_d;
    logic [NumBanks-1:0][BankDW-1:0] wdata_q, wdata_d;
    logic [NumBanks-1:0][BankSW-1:0] strb_q, strb_d;
    logic [NumBanks-1:0]             we_q, we_d;
    logic [AddrWidth-1:0]            addr_q, addr_d;
    atop_t                           atop_q, atop_d;
    logic [CntW-1:0]                 outst_q, outst_d;

    logic [NumBanks-1:0] capture;
    logic                issue;
    logic                retire;

    // Only bank 0 supplies address and atop; other banks' copies are ignored.
    logic unused_sig;
    assign unused_sig = ^{bank_addr_i, bank_atop_i, we_q};

    assign bank_gnt_o = ~valid_q;
    assign capture    = bank_req_i & ~valid_q;
    assign req_o      = (&valid_q) & (outst_q < MaxCnt);
    assign issue      = req_o & gnt_i;
    // A response with nothing outstanding is stale (e.g. issued before reset).
    assign retire     = rvalid_i & (outst_q != '0);

    assign addr_o  = addr_q & ~OffMask;
    assign wdata_o = wdata_q;
    assign strb_o  = strb_q;
    assign atop_o  = atop_q;
    assign we_o    = we_q[0];

    assign bank_rvalid_o = {NumBanks{retire}};
    assign bank_rdata_o  = rdata_i;

    // Next state of the per-bank capture buffers.
    always_comb begin
        valid_d = valid_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        atop_d  = atop_q;
        for (int i = 0; i < NumBanks; i++) begin
            if (capture[i]) begin
                valid_d[i] = 1'b1;
                wdata_d[i] = bank_wdata_i[i*BankDW +: BankDW];
                strb_d[i]  = bank_strb_i[i*BankSW +: BankSW];
                we_d[i]    = bank_we_i[i];
            end
        end
        if (capture[0]) begin
            addr_d = bank_addr_i[AddrWidth-1:0];
            atop_d = atop_t'(bank_atop_i[AtopWidth-1:0]);
        end
        if (issue) begin
            valid_d = '0;
        end
    end

    // Next state of the outstanding wide-request counter.
    always_comb begin
        outst_d = outst_q;
        if (issue && !retire) begin
            outst_d = outst_q + CntW'(1);
        end else if (retire && !issue) begin
            outst_d = outst_q - CntW'(1);
        end
    end

    // Buffer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            atop_q  <= '0;
            outst_q <= '0;
        end else begin
            valid_q <= valid_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            atop_q  <= atop_d;
            outst_q <= outst_d;
        end
    end

    a_we_match : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        req_o |-> (we_q == {NumBanks{we_q[0]}})
    );

    a_no_stray_rvalid : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        rvalid_i |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_banks_to_mem.sv
// Bench for banks_to_mem: vector table, directed corner sequences and
// a randomized phase checked against a transaction-level model.
module tb_banks_to_mem;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TW = 6;
    localparam int NB = 2;
    localparam int MT = 4;

    logic            clk_i;
    logic            rst_ni;
    logic [NB-1:0]   bank_req_i;
    logic [NB-1:0]   bank_gnt_o;
    logic [NB*AW-1:0] bank_addr_i;
    logic [DW-1:0]   bank_wdata_i;
    logic [DW/8-1:0] bank_strb_i;
    logic [NB*TW-1:0] bank_atop_i;
    logic [NB-1:0]   bank_we_i;
    logic [NB-1:0]   bank_rvalid_o;
    logic [DW-1:0]   bank_rdata_o;
    logic            req_o;
    logic            gnt_i;
    logic [AW-1:0]   addr_o;
    logic [DW-1:0]   wdata_o;
    logic [DW/8-1:0] strb_o;
    logic [TW-1:0]   atop_o;
    logic            we_o;
    logic            rvalid_i;
    logic [DW-1:0]   rdata_i;

    banks_to_mem dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bank_req_i   (bank_req_i),
        .bank_gnt_o   (bank_gnt_o),
        .bank_addr_i  (bank_addr_i),
        .bank_wdata_i (bank_wdata_i),
        .bank_strb_i  (bank_strb_i),
        .bank_atop_i  (bank_atop_i),
        .bank_we_i    (bank_we_i),
        .bank_rvalid_o(bank_rvalid_o),
        .bank_rdata_o (bank_rdata_o),
        .req_o        (req_o),
        .gnt_i        (gnt_i),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o),
        .strb_o       (strb_o),
        .atop_o       (atop_o),
        .we_o         (we_o),
        .rvalid_i     (rvalid_i),
        .rdata_i      (rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_bank(input int b, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            input logic [5:0] at, input logic we);
        bank_addr_i[b*AW +: AW]  = a;
        bank_wdata_i[b*32 +: 32] = wd;
        bank_strb_i[b*4 +: 4]    = st;
        bank_atop_i[b*TW +: TW]  = at;
        bank_we_i[b]             = we;
    endtask

    task automatic drive_idle();
        bank_req_i   = '0;
        bank_addr_i  = '0;
        bank_wdata_i = '0;
        bank_strb_i  = '0;
        bank_atop_i  = '0;
        bank_we_i    = '0;
        gnt_i        = 1'b0;
        rvalid_i     = 1'b0;
        rdata_i      = '0;
    endtask

    // Both banks hand over a request in the same cycle.
    task automatic gather(input logic we, input logic [31:0] base,
                          input logic [31:0] d0, input logic [31:0] d1);
        set_bank(0, base, d0, 4'hF, 6'h0, we);
        set_bank(1, base + 32'd4, d1, 4'hF, 6'h0, we);
        bank_req_i = 2'b11;
        tick();
        bank_req_i = 2'b00;
    endtask

    // Gather and expect the wide request to go out (gnt_i held high).
    task automatic issue_one(input string nm);
        gnt_i = 1'b1;
        gather(1'b0, 32'h1000, 32'h0, 32'h0);
        #1 chk(nm, 64'(req_o), 64'd1);
        tick();
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] addr;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [3:0]  st0;
        logic [3:0]  st1;
        logic        we;
        logic        gnt;
        logic        rv;
        logic [63:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_strb;
        logic        e_we;
        logic [1:0]  e_rv;
    } vec_t;

    vec_t tbl [9];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [5:0]  at;
        logic        we;
    } item_t;

    int          held_n [NB];
    item_t       held_it [NB];
    item_t       drv [NB];
    int          outs_m;
    logic        cur_we;
    logic [1:0]  e_gnt;
    logic        e_req;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b11, 32'h100, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1,
                   1'b0, 64'h0,
                   2'b11, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b00};
        tbl[1] = '{2'b00, 32'h100, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1,
                   1'b0, 64'h0,
                   2'b00, 1'b1, 32'h100, 64'h0, 8'h0, 1'b0, 2'b00};
        tbl[2] = '{2'b00, 32'h100, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0,
                   1'b1, 64'hDEADBEEF_01234567,
                   2'b11, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b11};
        tbl[3] = '{2'b01, 32'h200, 32'h11111111, 32'h0, 4'hF, 4'h0, 1'b1,
                   1'b1, 1'b0, 64'h0,
                   2'b11, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b00};
        tbl[4] = '{2'b00, 32'h200, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1,
                   1'b0, 64'h0,
                   2'b10, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b00};
        tbl[5] = '{2'b00, 32'h200, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1,
                   1'b0, 64'h0,
                   2'b10, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b00};
        tbl[6] = '{2'b10, 32'h200, 32'h0, 32'h22222222, 4'h0, 4'h3, 1'b1,
                   1'b1, 1'b0, 64'h0,
                   2'b10, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b00};
        tbl[7] = '{2'b00, 32'h200, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1,
                   1'b0, 64'h0,
                   2'b00, 1'b1, 32'h200, 64'h22222222_11111111, 8'h3F,
                   1'b1, 2'b00};
        tbl[8] = '{2'b00, 32'h200, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0,
                   1'b1, 64'hCAFEF00D_12345678,
                   2'b11, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 2'b11};

        // Reset state.
        drive_idle();
        rst_ni = 1'b0;
        #1 chk("rst_gnt_during", 64'(bank_gnt_o), 64'h3);
        chk("rst_req_during", 64'(req_o), 64'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        #1 chk("rst_gnt_after", 64'(bank_gnt_o), 64'h3);
        chk("rst_req_after", 64'(req_o), 64'h0);
        tick();

        // Aligned read and staggered write vectors.
        for (int i = 0; i < 9; i++) begin
            set_bank(0, tbl[i].addr, tbl[i].wd0, tbl[i].st0, 6'h0, tbl[i].we);
            set_bank(1, tbl[i].addr + 32'd4, tbl[i].wd1, tbl[i].st1, 6'h0,
                     tbl[i].we);
            bank_req_i = tbl[i].req;
            gnt_i      = tbl[i].gnt;
            rvalid_i   = tbl[i].rv;
            rdata_i    = tbl[i].rdata;
            #1;
            chk($sformatf("vec%0d_gnt", i), 64'(bank_gnt_o), 64'(tbl[i].e_gnt));
            chk($sformatf("vec%0d_req", i), 64'(req_o), 64'(tbl[i].e_req));
            chk($sformatf("vec%0d_rv", i), 64'(bank_rvalid_o), 64'(tbl[i].e_rv));
            if (tbl[i].e_req) begin
                chk($sformatf("vec%0d_addr", i), 64'(addr_o), 64'(tbl[i].e_addr));
                chk($sformatf("vec%0d_wdata", i), wdata_o, tbl[i].e_wdata);
                chk($sformatf("vec%0d_strb", i), 64'(strb_o), 64'(tbl[i].e_strb));
                chk($sformatf("vec%0d_we", i), 64'(we_o), 64'(tbl[i].e_we));
            end
            if (tbl[i].e_rv != 2'b00) begin
                chk($sformatf("vec%0d_rd0", i), 64'(bank_rdata_o[31:0]),
                    64'(tbl[i].rdata[31:0]));
                chk($sformatf("vec%0d_rd1", i), 64'(bank_rdata_o[63:32]),
                    64'(tbl[i].rdata[63:32]));
            end
            tick();
        end
        drive_idle();

        // Backpressure: payload held stable, banks blocked, new data ignored.
        gather(1'b1, 32'h345, 32'hA5A5_0001, 32'h5A5A_0002);
        set_bank(0, 32'h900, 32'hFFFF_FFFF, 4'h1, 6'h3F, 1'b0);
        set_bank(1, 32'h904, 32'hEEEE_EEEE, 4'h2, 6'h3F, 1'b0);
        bank_req_i = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req", 64'(req_o), 64'd1);
            chk("bp_gnt", 64'(bank_gnt_o), 64'h0);
            chk("bp_wdata", wdata_o, 64'h5A5A0002_A5A50001);
            chk("bp_addr", 64'(addr_o), 64'h340);
            chk("bp_we", 64'(we_o), 64'd1);
            tick();
        end
        bank_req_i = 2'b00;
        gnt_i = 1'b1;
        #1 chk("bp_req_grant", 64'(req_o), 64'd1);
        tick();
        gnt_i = 1'b0;
        chk("bp_regrant", 64'(bank_gnt_o), 64'h3);
        rvalid_i = 1'b1;
        rdata_i  = 64'h01020304_05060708;
        #1 chk("bp_rvalid", 64'(bank_rvalid_o), 64'h3);
        tick();
        rvalid_i = 1'b0;

        // Outstanding limit.
        for (int k = 0; k < MT; k++) issue_one("lim_issue");
        gather(1'b0, 32'h2000, 32'h1, 32'h2);
        for (int k = 0; k < 3; k++) begin
            #1 chk("lim_block", 64'(req_o), 64'd0);
            tick();
        end
        rvalid_i = 1'b1;
        #1 chk("lim_block_rv", 64'(req_o), 64'd0);
        tick();
        rvalid_i = 1'b0;
        #1 chk("lim_release", 64'(req_o), 64'd1);
        tick();
        rvalid_i = 1'b1;
        tick();
        tick();
        rvalid_i = 1'b0;

        // Issue and response together with two outstanding.
        gather(1'b1, 32'h3000, 32'h3, 32'h4);
        rvalid_i = 1'b1;
        #1 chk("sim_req", 64'(req_o), 64'd1);
        tick();
        rvalid_i = 1'b0;
        issue_one("sim_fill");
        issue_one("sim_fill");
        gather(1'b0, 32'h3100, 32'h5, 32'h6);
        #1 chk("sim_full", 64'(req_o), 64'd0);

        // Bring state to one bank held and three outstanding.
        rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        tick();
        rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        set_bank(0, 32'h4000, 32'h7, 4'hF, 6'h0, 1'b0);
        bank_req_i = 2'b01;
        tick();
        bank_req_i = 2'b00;
        gnt_i = 1'b0;
        #1 chk("pre_rst_gnt", 64'(bank_gnt_o), 64'h2);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", 64'(req_o), 64'd0);
        chk("arst_gnt", 64'(bank_gnt_o), 64'h3);
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < MT; k++) issue_one("arst_cnt_issue");
        gather(1'b0, 32'h5000, 32'h8, 32'h9);
        #1 chk("arst_cnt_block", 64'(req_o), 64'd0);

        // Randomized phase against a transaction-level model.
        rst_ni = 1'b0;
        drive_idle();
        tick();
        rst_ni = 1'b1;
        for (int b = 0; b < NB; b++) held_n[b] = 0;
        outs_m = 0;
        cur_we = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < NB; b++) begin
                drv[b].addr = $urandom();
                drv[b].wd   = $urandom();
                drv[b].st   = 4'($urandom());
                drv[b].at   = 6'($urandom());
                drv[b].we   = cur_we;
                set_bank(b, drv[b].addr, drv[b].wd, drv[b].st, drv[b].at,
                         drv[b].we);
                bank_req_i[b] = 1'($urandom_range(0, 1));
            end
            gnt_i    = ($urandom_range(0, 3) != 0);
            rvalid_i = (outs_m > 0) && ($urandom_range(0, 2) == 0);
            rdata_i  = {$urandom(), $urandom()};
            #1;
            for (int b = 0; b < NB; b++) e_gnt[b] = (held_n[b] == 0);
            e_req = (held_n[0] == 1) && (held_n[1] == 1) && (outs_m < MT);
            chk("rnd_gnt", 64'(bank_gnt_o), 64'(e_gnt));
            chk("rnd_req", 64'(req_o), 64'(e_req));
            chk("rnd_rv", 64'(bank_rvalid_o), rvalid_i ? 64'h3 : 64'h0);
            if (rvalid_i) begin
                chk("rnd_rd0", 64'(bank_rdata_o[31:0]), 64'(rdata_i[31:0]));
                chk("rnd_rd1", 64'(bank_rdata_o[63:32]), 64'(rdata_i[63:32]));
            end
            if (e_req) begin
                chk("rnd_addr", 64'(addr_o), 64'(held_it[0].addr & ~32'h7));
                chk("rnd_wdata", wdata_o, {held_it[1].wd, held_it[0].wd});
                chk("rnd_strb", 64'(strb_o), 64'({held_it[1].st, held_it[0].st}));
                chk("rnd_we", 64'(we_o), 64'(held_it[0].we));
                chk("rnd_atop", 64'(atop_o), 64'(held_it[0].at));
            end
            if (e_req && gnt_i) begin
                for (int b = 0; b < NB; b++) held_n[b] = 0;
                outs_m++;
                cur_we = 1'($urandom());
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (bank_req_i[b] && held_n[b] == 0) begin
                        held_n[b]  = 1;
                        held_it[b] = drv[b];
                    end
                end
            end
            if (rvalid_i) outs_m--;
            tick();
        end
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
